wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage that sits directly downstream of the M/W pipeline register. It extracts and extends load data, selects the register write-data source, and owns the 32x32 general register file. Read ports with write-through bypass serve the D stage. The selected write data is also driven out for hazard forwarding into the E and M stages.

Parameters:
DATA_W, 32, datapath width (fixed at 32; present for readability only)
TRACE_EN, 1, 1 = drive commit-trace outputs; 0 = tie trace outputs to 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
W_PC_i  in  32  PC of instruction in W
W_ALUop_i  in  8  operation code; selects load extraction
W_MemRead_i  in  32  raw aligned word read from data memory
W_ALUout_i  in  32  ALU result / memory address
W_HI_i  in  32  HI value
W_LO_i  in  32  LO value
W_CP0out_i  in  32  mfc0 result
W_RegWrite_i  in  1  register write request
W_RegA3_i  in  5  destination register
W_RegWDsel_i  in  4  write-data source select
D_A1_i  in  5  read address 1
D_A2_i  in  5  read address 2
D_RD1_o  out  32  read data 1 (bypassed)
D_RD2_o  out  32  read data 2 (bypassed)
W_RegWD_o  out  32  selected write data (forwarding)
W_WE_o  out  1  effective write enable (RegWrite_i and A3 != 0)
W_RegA3_o  out  5  W_RegA3_i passthrough for hazard unit
trace_valid_o  out  1  registered: a write committed last cycle
trace_pc_o  out  32  registered PC of committed write
trace_reg_o  out  5  registered destination
trace_data_o  out  32  registered write data

Behaviour:
- Reset (reset==0, async): regs 1..31 <= 0; trace_valid_o <= 0, trace_pc_o <= 32'h3000, trace_reg_o <= 0, trace_data_o <= 0. Combinational outputs follow their inputs during reset; D_RD* read 0 from cleared regs. Bypass is inactive while reset==0.
- Register 0 is hardwired 0: never written, always reads 0. No bypass applies to address 0.
- Load extraction uses off = W_ALUout_i[1:0], byte lane k = MemRead[8k+7:8k].
- OP_LW: word.
- OP_LB / OP_LBU: lane off, sign- / zero-extended.
- OP_LH / OP_LHU: half off[1] (off[0] ignored), sign- / zero-extended.
- Any other op: word unchanged.
- WD mux: SEL_ALU -> ALUout; SEL_MEM -> extracted load; SEL_PC8 -> W_PC_i+8 (mod 2^32); SEL_HI -> HI; SEL_LO -> LO; SEL_CP0 -> CP0out; undefined codes -> 0.
- Write: on posedge clk with reset==1 and W_WE_o==1, regs[A3] <= W_RegWD_o. Latency is 1 edge to the array.
- Read: combinational. If reset==1, W_WE_o==1 and A3==D_Ax, return W_RegWD_o (same-cycle write-through); otherwise return the array value. Both ports may hit the bypass simultaneously.
- Trace: each edge with reset==1 (only when TRACE_EN=1), trace_valid_o <= W_WE_o. When W_WE_o==1, also latch PC, A3 and WD. Otherwise hold PC, A3 and data.
- A bubble from upstream (RegWrite=0) produces no write and trace_valid_o=0.
- Reset asserted mid-write: the async clear wins and no write occurs.

Decomposition:
- Package mips_pkg:
  - SEL_ALU=4'd0, SEL_MEM=4'd1, SEL_PC8=4'd2, SEL_HI=4'd3, SEL_LO=4'd4, SEL_CP0=4'd5
  - OP_LW=8'd32, OP_LB=8'd33, OP_LBU=8'd34, OP_LH=8'd35, OP_LHU=8'd36
  - RESET_PC=32'h3000
- One sub-module, grf: 31x32 array, async active-low clear, 1 write port, 2 combinational read ports with write-through bypass.
- Load extraction and WD mux stay in wb_stage.

Test Plan:
- Reset: hold reset=0, then release. D_A1=5 -> D_RD1=0; trace_valid_o=0; trace_pc_o=32'h3000.
- Loads: MemRead=32'h80FF7F01, SEL_MEM.
  - LB, off=3 -> WD=32'hFFFFFF80.
  - LBU, off=1 -> 32'h0000007F.
  - LH, off=2 -> 32'hFFFF80FF.
  - LHU, off=0 -> 32'h00007F01.
  - LW -> 32'h80FF7F01.
- Write + bypass: RegWrite=1, A3=8, SEL_ALU, ALUout=32'hDEADBEEF, D_A1=D_A2=8. Same cycle: both RD outputs = DEADBEEF. Next cycle with RegWrite=0: still DEADBEEF from the array. trace_valid_o=1, trace_reg_o=8.
- $0 protection: RegWrite=1, A3=0, ALUout=32'h1234 -> W_WE_o=0, D_RD1(A1=0)=0, trace_valid_o=0 next cycle.
- Other sources:
  - SEL_PC8 with PC=32'hFFFFFFFC -> WD=32'h00000004.
  - SEL_HI -> HI; SEL_LO -> LO; SEL_CP0 -> CP0out.
  - WDsel=4'd9 -> WD=0.
- Async reset mid-run: write regs 3 and 31, then pull reset low between edges. RD for both returns 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and payload types for the write-back stage.
package mips_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned OP_W     = 8;

   localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_3000;

   // Register write-data source codes
   typedef enum logic [SEL_W-1:0] {
      SEL_ALU = 4'd0,
      SEL_MEM = 4'd1,
      SEL_PC8 = 4'd2,
      SEL_HI  = 4'd3,
      SEL_LO  = 4'd4,
      SEL_CP0 = 4'd5
   } wd_sel_e;

   // Operation codes that change how the memory word is extracted
   typedef enum logic [OP_W-1:0] {
      OP_LW  = 8'd32,
      OP_LB  = 8'd33,
      OP_LBU = 8'd34,
      OP_LH  = 8'd35,
      OP_LHU = 8'd36
   } load_op_e;

   // One committed register write as seen by the trace port
   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [REG_AW-1:0] rd;
      logic [WORD_W-1:0] data;
   } trace_t;

endpackage

// File: rtl/grf.sv
// General register file: 31 writable words ($0 hardwired to zero),
// one write port, two combinational read ports with write-through bypass.
module grf
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] a3,
   input  logic [WORD_W-1:0] wd,
   input  logic [REG_AW-1:0] a1,
   input  logic [REG_AW-1:0] a2,
   output logic [WORD_W-1:0] rd1,
   output logic [WORD_W-1:0] rd2
);

   logic [WORD_W-1:0] regs [1:31];
   logic              wr_hit;

   // A write is only real for a nonzero destination outside reset
   assign wr_hit = reset && we && (a3 != '0);

   // Register array: async clear, single write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (a3 != '0)) begin
         regs[a3] <= wd;
      end
   end

   // Read port 1: zero for $0, same-cycle write data on address match
   always_comb begin
      rd1 = '0;
      if (a1 != '0) begin
         if (wr_hit && (a3 == a1)) begin
            rd1 = wd;
         end else begin
            rd1 = regs[a1];
         end
      end
   end

   // Read port 2: same rules as port 1
   always_comb begin
      rd2 = '0;
      if (a2 != '0) begin
         if (wr_hit && (a3 == a2)) begin
            rd2 = wd;
         end else begin
            rd2 = regs[a2];
         end
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load extraction, write-data select, register file
// ownership, forwarding outputs and an optional commit trace.
module wb_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W   = WORD_W,
   parameter bit          TRACE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] W_PC_i,
   input  logic [OP_W-1:0]   W_ALUop_i,
   input  logic [DATA_W-1:0] W_MemRead_i,
   input  logic [DATA_W-1:0] W_ALUout_i,
   input  logic [DATA_W-1:0] W_HI_i,
   input  logic [DATA_W-1:0] W_LO_i,
   input  logic [DATA_W-1:0] W_CP0out_i,
   input  logic              W_RegWrite_i,
   input  logic [REG_AW-1:0] W_RegA3_i,
   input  logic [SEL_W-1:0]  W_RegWDsel_i,
   input  logic [REG_AW-1:0] D_A1_i,
   input  logic [REG_AW-1:0] D_A2_i,
   output logic [DATA_W-1:0] D_RD1_o,
   output logic [DATA_W-1:0] D_RD2_o,
   output logic [DATA_W-1:0] W_RegWD_o,
   output logic              W_WE_o,
   output logic [REG_AW-1:0] W_RegA3_o,
   output logic              trace_valid_o,
   output logic [DATA_W-1:0] trace_pc_o,
   output logic [REG_AW-1:0] trace_reg_o,
   output logic [DATA_W-1:0] trace_data_o
);

   logic [1:0]        off;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] pc8;
   logic [DATA_W-1:0] wd;
   logic              we;

   assign off = W_ALUout_i[1:0];
   assign pc8 = W_PC_i + DATA_W'(8);

   // Pick the addressed byte lane and half-word (off[0] ignored for halves)
   always_comb begin
      lane_b = W_MemRead_i[7:0];
      case (off)
         2'd0:    lane_b = W_MemRead_i[7:0];
         2'd1:    lane_b = W_MemRead_i[15:8];
         2'd2:    lane_b = W_MemRead_i[23:16];
         default: lane_b = W_MemRead_i[31:24];
      endcase
      lane_h = off[1] ? W_MemRead_i[31:16] : W_MemRead_i[15:0];
   end

   // Extend the selected lane according to the load flavour
   always_comb begin
      load_data = W_MemRead_i;
      case (W_ALUop_i)
         OP_LW:   load_data = W_MemRead_i;
         OP_LB:   load_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
         OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, lane_b};
         OP_LH:   load_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
         OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, lane_h};
         default: load_data = W_MemRead_i;
      endcase
   end

   // Write-data source mux; unassigned codes yield zero
   always_comb begin
      wd = '0;
      case (W_RegWDsel_i)
         SEL_ALU: wd = W_ALUout_i;
         SEL_MEM: wd = load_data;
         SEL_PC8: wd = pc8;
         SEL_HI:  wd = W_HI_i;
         SEL_LO:  wd = W_LO_i;
         SEL_CP0: wd = W_CP0out_i;
         default: wd = '0;
      endcase
   end

   assign we        = W_RegWrite_i && (W_RegA3_i != '0);
   assign W_WE_o    = we;
   assign W_RegWD_o = wd;
   assign W_RegA3_o = W_RegA3_i;

   grf u_grf (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .a3    (W_RegA3_i),
      .wd    (wd),
      .a1    (D_A1_i),
      .a2    (D_A2_i),
      .rd1   (D_RD1_o),
      .rd2   (D_RD2_o)
   );

   generate
      if (TRACE_EN) begin : g_trace
         trace_t trace_q;
         logic   valid_q;

         // Record each committed write; payload holds across idle cycles
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               valid_q <= 1'b0;
               trace_q <= '{pc: RESET_PC, rd: '0, data: '0};
            end else begin
               valid_q <= we;
               if (we) begin
                  trace_q <= '{pc: W_PC_i, rd: W_RegA3_i, data: wd};
               end
            end
         end

         assign trace_valid_o = valid_q;
         assign trace_pc_o    = trace_q.pc;
         assign trace_reg_o   = trace_q.rd;
         assign trace_data_o  = trace_q.data;
      end else begin : g_no_trace
         assign trace_valid_o = 1'b0;
         assign trace_pc_o    = '0;
         assign trace_reg_o   = '0;
         assign trace_data_o  = '0;
      end
   endgenerate

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc, mem, alu, hi, lo, cp0;
   logic [7:0]  op;
   logic        rw;
   logic [4:0]  a3, a1, a2;
   logic [3:0]  sel;

   logic [31:0] rd1, rd2, wd_o, tr_pc, tr_data;
   logic        we_o, tr_valid;
   logic [4:0]  a3_o, tr_reg;

   wb_stage dut (
      .clk           (clk),
      .reset         (reset),
      .W_PC_i        (pc),
      .W_ALUop_i     (op),
      .W_MemRead_i   (mem),
      .W_ALUout_i    (alu),
      .W_HI_i        (hi),
      .W_LO_i        (lo),
      .W_CP0out_i    (cp0),
      .W_RegWrite_i  (rw),
      .W_RegA3_i     (a3),
      .W_RegWDsel_i  (sel),
      .D_A1_i        (a1),
      .D_A2_i        (a2),
      .D_RD1_o       (rd1),
      .D_RD2_o       (rd2),
      .W_RegWD_o     (wd_o),
      .W_WE_o        (we_o),
      .W_RegA3_o     (a3_o),
      .trace_valid_o (tr_valid),
      .trace_pc_o    (tr_pc),
      .trace_reg_o   (tr_reg),
      .trace_data_o  (tr_data)
   );

   always #5 clk = ~clk;

   localparam int K_WD = 0, K_WE = 1, K_RD1 = 2, K_RD2 = 3, K_A3 = 4;
   localparam int K_TV = 5, K_TPC = 6, K_TREG = 7, K_TDATA = 8;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Behavioural model state
   logic [31:0] mregs [32];
   logic        m_tv;
   logic [31:0] m_tpc, m_tdata;
   logic [4:0]  m_treg;

   function automatic logic [31:0] m_load(input logic [7:0] o, input logic [31:0] m,
                                          input logic [31:0] addr);
      int unsigned k;
      logic [31:0] b, h;
      k = addr % 32'd4;
      b = (m >> (8 * k)) & 32'hFF;
      h = (m >> (16 * (k / 2))) & 32'hFFFF;
      case (o)
         8'd33:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         8'd34:   return b;
         8'd35:   return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
         8'd36:   return h;
         default: return m;
      endcase
   endfunction

   function automatic logic [31:0] m_wd();
      case (sel)
         4'd0:    return alu;
         4'd1:    return m_load(op, mem, alu);
         4'd2:    return pc + 32'd8;
         4'd3:    return hi;
         4'd4:    return lo;
         4'd5:    return cp0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_we();
      return rw && (a3 != 5'd0);
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (reset && m_we() && (a3 == a)) return m_wd();
      return mregs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      m_tv = 1'b0; m_tpc = 32'h3000; m_treg = 5'd0; m_tdata = 32'd0;
   endtask

   // What the clock edge does to architectural state
   task automatic model_edge();
      if (reset) begin
         m_tv = m_we();
         if (m_we()) begin
            mregs[a3] = m_wd();
            m_tpc = pc; m_treg = a3; m_tdata = m_wd();
         end
      end
   endtask

   task automatic push(input string name, input int kind, input logic [31:0] e);
      exp_t x;
      x.name = name; x.kind = kind; x.exp = e;
      q.push_back(x);
   endtask

   task automatic apply_reset(input logic v);
      reset = v;
      if (!v) model_reset();
   endtask

   // Queue model expectations, let the monitor check, then advance one edge
   task automatic cycle(input string name);
      push({name, ".wd"},    K_WD,    m_wd());
      push({name, ".we"},    K_WE,    {31'd0, m_we()});
      push({name, ".rd1"},   K_RD1,   m_rd(a1));
      push({name, ".rd2"},   K_RD2,   m_rd(a2));
      push({name, ".a3"},    K_A3,    {27'd0, a3});
      push({name, ".tv"},    K_TV,    {31'd0, m_tv});
      push({name, ".tpc"},   K_TPC,   m_tpc);
      push({name, ".treg"},  K_TREG,  {27'd0, m_treg});
      push({name, ".tdata"}, K_TDATA, m_tdata);
      @(negedge clk);
      #1;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] actual(input int kind);
      case (kind)
         K_WD:    return wd_o;
         K_WE:    return {31'd0, we_o};
         K_RD1:   return rd1;
         K_RD2:   return rd2;
         K_A3:    return {27'd0, a3_o};
         K_TV:    return {31'd0, tr_valid};
         K_TPC:   return tr_pc;
         K_TREG:  return {27'd0, tr_reg};
         default: return tr_data;
      endcase
   endfunction

   // Monitor: compare every pending expectation against the settled outputs
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t x;
         logic [31:0] a;
         x = q.pop_front();
         a = actual(x.kind);
         n_cmp++;
         if (a !== x.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", x.name, a, x.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      pc = 32'h3000; op = 8'd32; mem = 32'd0; alu = 32'd0; hi = 32'd0; lo = 32'd0;
      cp0 = 32'd0; rw = 1'b0; a3 = 5'd0; sel = 4'd0; a1 = 5'd5; a2 = 5'd0;
      apply_reset(1'b0);

      // Reset state
      push("rst.rd1", K_RD1, 32'd0);
      push("rst.tv", K_TV, 32'd0);
      push("rst.tpc", K_TPC, 32'h3000);
      cycle("rst");
      cycle("rst2");
      apply_reset(1'b1);
      cycle("idle");

      // Load extraction
      mem = 32'h80FF7F01; sel = 4'd1;
      op = 8'd33; alu = 32'h103; push("lb3", K_WD, 32'hFFFFFF80); cycle("lb3");
      op = 8'd34; alu = 32'h101; push("lbu1", K_WD, 32'h0000007F); cycle("lbu1");
      op = 8'd35; alu = 32'h102; push("lh2", K_WD, 32'hFFFF80FF); cycle("lh2");
      op = 8'd36; alu = 32'h100; push("lhu0", K_WD, 32'h00007F01); cycle("lhu0");
      op = 8'd32; alu = 32'h100; push("lw", K_WD, 32'h80FF7F01); cycle("lw");

      // Write with same-cycle bypass, then readback from the array
      rw = 1'b1; a3 = 5'd8; sel = 4'd0; alu = 32'hDEADBEEF; a1 = 5'd8; a2 = 5'd8;
      push("byp.rd1", K_RD1, 32'hDEADBEEF); push("byp.rd2", K_RD2, 32'hDEADBEEF);
      cycle("byp");
      rw = 1'b0; alu = 32'd0;
      push("arr.rd1", K_RD1, 32'hDEADBEEF); push("arr.rd2", K_RD2, 32'hDEADBEEF);
      push("arr.tv", K_TV, 32'd1); push("arr.treg", K_TREG, 32'd8);
      cycle("arr");

      // $0 protection
      rw = 1'b1; a3 = 5'd0; alu = 32'h1234; a1 = 5'd0;
      push("z.we", K_WE, 32'd0); push("z.rd1", K_RD1, 32'd0);
      cycle("z");
      rw = 1'b0;
      push("z2.tv", K_TV, 32'd0);
      cycle("z2");

      // Remaining sources
      sel = 4'd2; pc = 32'hFFFFFFFC; push("pc8", K_WD, 32'h4); cycle("pc8");
      hi = 32'h11112222; sel = 4'd3; push("hi", K_WD, 32'h11112222); cycle("hi");
      lo = 32'h33334444; sel = 4'd4; push("lo", K_WD, 32'h33334444); cycle("lo");
      cp0 = 32'h55556666; sel = 4'd5; push("cp0", K_WD, 32'h55556666); cycle("cp0");
      sel = 4'd9; push("sel9", K_WD, 32'h0); cycle("sel9");

      // Async reset between edges
      sel = 4'd0; rw = 1'b1; a3 = 5'd3; alu = 32'hAAAA5555; cycle("w3");
      a3 = 5'd31; alu = 32'h0F0F0F0F; cycle("w31");
      rw = 1'b0; a1 = 5'd3; a2 = 5'd31;
      push("pre.rd1", K_RD1, 32'hAAAA5555); push("pre.rd2", K_RD2, 32'h0F0F0F0F);
      cycle("pre");
      rw = 1'b1; a3 = 5'd3; alu = 32'h77;
      apply_reset(1'b0);
      push("ar.rd1", K_RD1, 32'd0); push("ar.rd2", K_RD2, 32'd0);
      push("ar.tv", K_TV, 32'd0); push("ar.tpc", K_TPC, 32'h3000);
      cycle("ar");
      rw = 1'b0;
      apply_reset(1'b1);
      push("post.rd1", K_RD1, 32'd0);
      cycle("post");

      // Randomized traffic with occasional async resets
      for (int n = 0; n < 400; n++) begin
         if (!reset) apply_reset(1'b1);
         else if ($urandom_range(0, 63) == 0) apply_reset(1'b0);
         pc  = $urandom; mem = $urandom; alu = $urandom;
         hi  = $urandom; lo  = $urandom; cp0 = $urandom;
         op  = 8'(30 + $urandom_range(0, 8));
         sel = 4'($urandom_range(0, 7));
         rw  = 1'($urandom_range(0, 1));
         a3  = 5'($urandom_range(0, 31));
         a1  = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
         a2  = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
         cycle("rnd");
      end

      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
